// File: rtl/uart_echo_if.sv
// Pin-level bundle for the UART echo core: serial lines, echo/flag controls and status.
// The master side drives the receive line and controls; the core is the slave.
interface uart_echo_if #(
  parameter int LVL_W = 5
) ();
  logic             UART_TXD_IN;
  logic             UART_RXD_OUT;
  logic             echo_en;
  logic             clr_err;
  logic [LVL_W-1:0] fifo_level;
  logic             frame_err;
  logic             parity_err;
  logic             overflow;

  modport master (
    output UART_TXD_IN, echo_en, clr_err,
    input  UART_RXD_OUT, fifo_level, frame_err, parity_err, overflow
  );

  modport slave (
    input  UART_TXD_IN, echo_en, clr_err,
    output UART_RXD_OUT, fifo_level, frame_err, parity_err, overflow
  );
endinterface

// File: rtl/uart_echo.sv
// UART loopback: receives frames, queues data words in a FIFO and retransmits them.
// Word width, parity, stop bits, bit period and FIFO depth are parameters.
module uart_echo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  uart_echo_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             PAR_EN    = (PARITY != 0);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.UART_TXD_IN;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  state_e               rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_data_d  = rx_data_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        // A line already back high at mid-start was a glitch.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d  = '0;
          rx_data_d = {rx_sync_q, rx_data_q[DATA_BITS-1:1]};
          rx_idx_d  = rx_idx_q + 3'd1;
          if (rx_idx_q == LAST_BIT) rx_state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_done    = 1'b1;
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_data_q  <= rx_data_d;
      rx_par_q   <= rx_par_d;
    end
  end

  logic             par_ok, rx_good, full, wr_en, pop;
  logic             frame_set, par_set, ovf_set;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             frame_err_q, parity_err_q, overflow_q;

  assign par_ok    = !PAR_EN || ((^rx_data_q ^ rx_par_q) == PAR_ODD);
  assign frame_set = rx_done && !rx_sync_q;
  assign par_set   = rx_done && rx_sync_q && !par_ok;
  assign rx_good   = rx_done && rx_sync_q && par_ok;
  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  // A same-cycle pop frees a slot, so a full FIFO can still accept the word.
  assign wr_en     = rx_good && (!full || pop);
  assign ovf_set   = rx_good && full && !pop;

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q      <= level_d;
      frame_err_q  <= frame_set | (frame_err_q  & ~bus.clr_err);
      parity_err_q <= par_set   | (parity_err_q & ~bus.clr_err);
      overflow_q   <= ovf_set   | (overflow_q   & ~bus.clr_err);
    end
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] tx_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data_q;
    if (pop)   tx_data_q <= mem_q[rd_ptr_q];
  end

  state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_par;

  assign tx_par = (^tx_data_q) ^ PAR_ODD;

  // tx_line_d is the level of the bit being entered, so the pin is a plain flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_line_d  = tx_line_q;
    pop        = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        if (bus.echo_en && (level_q != '0)) begin
          pop        = 1'b1;
          tx_state_d = S_START;
          tx_line_d  = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = S_DATA;
          tx_line_d  = tx_data_q[0];
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_idx_q == LAST_BIT) begin
            tx_idx_d   = '0;
            tx_state_d = PAR_EN ? S_PARITY : S_STOP;
            tx_line_d  = PAR_EN ? tx_par : 1'b1;
          end else begin
            tx_idx_d  = tx_idx_q + 3'd1;
            tx_line_d = tx_data_q[tx_idx_d];
          end
        end
      end
      S_PARITY: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = S_STOP;
          tx_line_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_idx_q[0] == LAST_STOP) tx_state_d = S_IDLE;
          else                          tx_idx_d   = tx_idx_q + 3'd1;
          tx_line_d = 1'b1;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign bus.UART_RXD_OUT = tx_line_q;
  assign bus.fifo_level   = level_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_uart_echo.sv
// Bench for uart_echo: instance A is 8 data bits / even parity / 1 stop / depth 4,
// instance B is 5 data bits / odd parity / 2 stops / depth 4; both at 16 clocks per bit.
module tb_uart_echo;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_echo_if #(.LVL_W(3)) ifa ();
  uart_echo_if #(.LVL_W(3)) ifb ();

  uart_echo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_echo #(.CLKS_PER_BIT(16), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start_ok;
    logic       stop_ok;
    int         fall;
  } frame_t;

  frame_t q_a[$];
  frame_t q_b[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_fe;
    logic       exp_pe;
    logic       exp_echo;
  } vec_t;

  function automatic logic line_of(input int sel);
    return (sel == 0) ? ifa.UART_RXD_OUT : ifb.UART_RXD_OUT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) ifa.UART_TXD_IN = v;
    else          ifb.UART_TXD_IN = v;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input logic par, input logic stop);
    int nb;
    nb = (sel == 0) ? 8 : 5;
    drive(sel, 1'b0);
    repeat (16) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      drive(sel, data[i]);
      repeat (16) @(negedge clk);
    end
    drive(sel, par);
    repeat (16) @(negedge clk);
    drive(sel, stop);
    repeat (16) @(negedge clk);
    drive(sel, 1'b1);
  endtask

  task automatic pulse_clr(input int sel);
    if (sel == 0) ifa.clr_err = 1'b1; else ifb.clr_err = 1'b1;
    @(negedge clk);
    if (sel == 0) ifa.clr_err = 1'b0; else ifb.clr_err = 1'b0;
    @(negedge clk);
  endtask

  // Decodes one transmitted frame by sampling each bit at its centre.
  task automatic mon(input int sel);
    frame_t f;
    int     nb;
    logic   prev, cur;
    nb = (sel == 0) ? 8 : 5;
    f.data = '0;
    prev = 1'b1;
    cur  = 1'b1;
    while (!(prev && !cur)) begin
      @(negedge clk);
      prev = cur;
      cur  = line_of(sel);
    end
    f.fall = cyc;
    repeat (7) @(negedge clk);
    f.start_ok = !line_of(sel);
    for (int i = 0; i < nb; i++) begin
      repeat (16) @(negedge clk);
      f.data[i] = line_of(sel);
    end
    repeat (16) @(negedge clk);
    f.par = line_of(sel);
    repeat (16) @(negedge clk);
    f.stop_ok = line_of(sel);
    if (sel == 0) q_a.push_back(f);
    else          q_b.push_back(f);
  endtask

  initial forever mon(0);
  initial forever mon(1);

  initial begin
    vec_t vecs[8];
    logic [7:0] d;
    logic found;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    ifa.UART_TXD_IN = 1'b1; ifa.echo_en = 1'b1; ifa.clr_err = 1'b0;
    ifb.UART_TXD_IN = 1'b1; ifb.echo_en = 1'b0; ifb.clr_err = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_line_a", ifa.UART_RXD_OUT, 1);
    chk("rst_level_a", ifa.fifo_level, 0);
    chk("rst_flags_a", {ifa.frame_err, ifa.parity_err, ifa.overflow}, 0);
    chk("rst_line_b", ifb.UART_RXD_OUT, 1);
    chk("rst_level_b", ifb.fifo_level, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      q_a.delete();
      send_frame(0, vecs[v].data, vecs[v].par, vecs[v].stop);
      repeat (200) @(negedge clk);
      $display("vec %0d data=%02h par=%0d stop=%0d echoes=%0d fe=%0d pe=%0d",
               v, vecs[v].data, vecs[v].par, vecs[v].stop, q_a.size(), ifa.frame_err, ifa.parity_err);
      chk($sformatf("v%0d_frame_err", v), ifa.frame_err, vecs[v].exp_fe);
      chk($sformatf("v%0d_parity_err", v), ifa.parity_err, vecs[v].exp_pe);
      chk($sformatf("v%0d_overflow", v), ifa.overflow, 0);
      chk($sformatf("v%0d_level", v), ifa.fifo_level, 0);
      chk($sformatf("v%0d_echo_cnt", v), q_a.size(), vecs[v].exp_echo ? 1 : 0);
      if (vecs[v].exp_echo && q_a.size() > 0) begin
        chk($sformatf("v%0d_echo_data", v), q_a[0].data, vecs[v].data);
        chk($sformatf("v%0d_echo_par", v), q_a[0].par, vecs[v].par);
        chk($sformatf("v%0d_echo_frame", v), {q_a[0].start_ok, q_a[0].stop_ok}, 2'b11);
      end
      pulse_clr(0);
      chk($sformatf("v%0d_clr", v), {ifa.frame_err, ifa.parity_err}, 0);
    end

    // Short low glitch must be rejected at the start-bit centre.
    q_a.delete();
    ifa.UART_TXD_IN = 1'b0;
    repeat (3) @(negedge clk);
    ifa.UART_TXD_IN = 1'b1;
    repeat (60) @(negedge clk);
    $display("glitch: level=%0d flags=%03b echoes=%0d", ifa.fifo_level,
             {ifa.frame_err, ifa.parity_err, ifa.overflow}, q_a.size());
    chk("glitch_flags", {ifa.frame_err, ifa.parity_err, ifa.overflow}, 0);
    chk("glitch_level", ifa.fifo_level, 0);
    chk("glitch_echo", q_a.size(), 0);

    // Overflow: five words into a depth-4 FIFO while echo is held off.
    ifa.echo_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(0, d, ^d, 1'b1);
      repeat (20) @(negedge clk);
      $display("ovf send %02h level=%0d overflow=%0d", d, ifa.fifo_level, ifa.overflow);
      if (i == 1) chk("ovf_level1", ifa.fifo_level, 1);
    end
    chk("ovf_level", ifa.fifo_level, 4);
    chk("ovf_flag", ifa.overflow, 1);
    chk("ovf_other_flags", {ifa.frame_err, ifa.parity_err}, 0);
    chk("ovf_no_tx", q_a.size(), 0);
    ifa.echo_en = 1'b1;
    repeat (800) @(negedge clk);
    chk("ovf_echo_cnt", q_a.size(), 4);
    for (int i = 0; i < 4 && i < q_a.size(); i++) begin
      $display("ovf echo %0d data=%02h par=%0d", i, q_a[i].data, q_a[i].par);
      chk($sformatf("ovf_echo%0d", i), q_a[i].data, i + 1);
    end
    chk("ovf_level_drain", ifa.fifo_level, 0);
    pulse_clr(0);
    chk("ovf_clr", ifa.overflow, 0);

    // Reset asserted during data bit 3 of an outgoing 0x00.
    ifa.echo_en = 1'b0;
    send_frame(0, 8'h00, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("rsttx_level_pre", ifa.fifo_level, 1);
    ifa.echo_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ifa.UART_RXD_OUT == 1'b0) found = 1'b1;
    end
    chk("rsttx_start_seen", found, 1);
    repeat (72) @(negedge clk);
    chk("rsttx_mid_low", ifa.UART_RXD_OUT, 0);
    #2 rst = 1'b1;
    #1;
    $display("reset mid-tx: line=%0d level=%0d", ifa.UART_RXD_OUT, ifa.fifo_level);
    chk("rsttx_line_high", ifa.UART_RXD_OUT, 1);
    chk("rsttx_level", ifa.fifo_level, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    q_a.delete();
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    repeat (200) @(negedge clk);
    chk("rsttx_echo_cnt", q_a.size(), 1);
    if (q_a.size() > 0) begin
      $display("post-reset echo data=%02h par=%0d", q_a[0].data, q_a[0].par);
      chk("rsttx_echo_data", q_a[0].data, 8'h5A);
      chk("rsttx_echo_par", q_a[0].par, 0);
    end

    // Instance B: 5-bit odd-parity frames with two stop bits, sent back to back.
    q_b.delete();
    send_frame(1, 8'h13, 1'b0, 1'b1);
    send_frame(1, 8'h0A, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("b_level_pre", ifb.fifo_level, 2);
    ifb.echo_en = 1'b1;
    repeat (400) @(negedge clk);
    chk("b_echo_cnt", q_b.size(), 2);
    if (q_b.size() >= 2) begin
      $display("b echo0 data=%02h par=%0d; echo1 data=%02h par=%0d; gap=%0d",
               q_b[0].data, q_b[0].par, q_b[1].data, q_b[1].par, q_b[1].fall - q_b[0].fall);
      chk("b_echo0_data", q_b[0].data, 8'h13);
      chk("b_echo0_par", q_b[0].par, 0);
      chk("b_echo0_frame", {q_b[0].start_ok, q_b[0].stop_ok}, 2'b11);
      chk("b_echo1_data", q_b[1].data, 8'h0A);
      chk("b_echo1_par", q_b[1].par, 1);
      chk("b_frame_spacing", q_b[1].fall - q_b[0].fall, 145);
    end
    chk("b_level_post", ifb.fifo_level, 0);
    chk("b_flags", {ifb.frame_err, ifb.parity_err, ifb.overflow}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_echo.md
# uart_echo

Parametrised UART loopback core: receives serial frames on `UART_TXD_IN`, buffers the data words in an internal FIFO, and retransmits them on `UART_RXD_OUT`. It is the next generation of the fixed 8N1 rx-to-tx loopback top. It adds configurable word width, parity, stop bits, baud divisor and buffer depth, plus error detection and flow control. It sits directly on the board UART pins.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit period (≥ 8).
- `DATA_BITS`, 8, data bits per frame, 5..8.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits transmitted, 1 or 2.
- `FIFO_DEPTH`, 16, FIFO entries, power of 2, ≥ 2.

- `clk` input 1: single clock for all logic.
- `rst` input 1: asynchronous, active-high reset.
- `UART_TXD_IN` input 1: serial receive line, asynchronous, idles high.
- `UART_RXD_OUT` output 1: serial transmit line, idles high.
- `echo_en` input 1: 1 allows the transmitter to pop the FIFO; 0 holds data in the FIFO.
- `clr_err` input 1: a single-cycle pulse clears all sticky error flags.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy, 0..FIFO_DEPTH.
- `frame_err` output 1: sticky flag; a received stop bit was sampled low.
- `parity_err` output 1: sticky flag; received parity did not match.
- `overflow` output 1: sticky flag; a valid word arrived while the FIFO was full.

## Operation
- Reset values:
  - `UART_RXD_OUT` = 1.
  - `fifo_level` = 0.
  - All error flags = 0.
  - Both FSMs in IDLE.
  - FIFO pointers = 0.
- RX path:
  - `UART_TXD_IN` passes through a 2-flop synchroniser.
  - FSM states: IDLE → START → DATA → PARITY (only when PARITY≠0) → STOP → IDLE.
  - IDLE: a synchronised 1→0 transition starts the bit counter.
  - START: the line is re-sampled at CLKS_PER_BIT/2 (integer division). If it reads high, the edge was a glitch; return to IDLE with no flag and no write.
  - DATA: one sample per CLKS_PER_BIT after the start-bit mid-point, LSB first, DATA_BITS samples.
  - PARITY: odd mode requires (data XOR-reduce ^ parity bit) = 1; even mode requires it to be 0.
  - STOP: exactly one stop bit is checked, regardless of STOP_BITS.
  - Stop sampled low: set `frame_err`, discard the word.
  - Parity mismatch with a good stop bit: set `parity_err`, discard the word.
  - Valid word with FIFO full: set `overflow`, discard the word; FIFO contents are unchanged.
- FIFO:
  - DATA_BITS wide, FIFO_DEPTH deep.
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Occupancy counter is kept separately.
  - A write and a pop in the same cycle leave `fifo_level` unchanged and are both legal, including when the FIFO is full (the pop frees the slot first) and when it is empty (the write is not poppable until the next cycle).
- TX path:
  - FSM states: IDLE → START → DATA → PARITY (only when PARITY≠0) → STOP → IDLE.
  - IDLE: when `echo_en`=1 and `fifo_level`≠0, pop one word into the shift register.
  - Frame sent: start bit 0, DATA_BITS data bits LSB first, then the parity bit if enabled, then STOP_BITS bits of 1.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - Dropping `echo_en` mid-frame does not truncate the frame; it only blocks the next pop.
- Error flags:
  - Set on the detection cycle and held until `clr_err`.
  - If a set event and `clr_err` occur in the same cycle, set wins.
- Reset mid-frame aborts both FSMs, forces `UART_RXD_OUT` high on assertion, and empties the FIFO.

## Timing
- RX write occurs in the cycle the stop-bit sample is taken. `fifo_level` increments on the next edge.
- Stop-bit sample position: about 1.5·CLKS_PER_BIT + (DATA_BITS + P)·CLKS_PER_BIT cycles after the synchronised start edge, where P = 1 if parity is enabled, else 0.
- TX pop occurs in the first IDLE cycle with the pop condition true. `UART_RXD_OUT` goes low on the following edge.
- Latency from RX stop-bit sample to TX start bit is 2 cycles when the FIFO was empty, TX was idle and `echo_en`=1.
- Back-to-back TX frames have zero idle gap beyond the stop bit(s) plus 1 cycle for the pop.
- `UART_RXD_OUT` is registered and glitch-free.
- Input synchronisation adds 2 cycles of RX latency.

## Test plan
- Echo, even parity (CLKS_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1):
  - Stimulus: send 0xA5 with parity bit 0.
  - Required: identical frame 0xA5 with parity 0 appears on `UART_RXD_OUT`; `fifo_level` returns to 0; no flags set.
- Parity error:
  - Stimulus: same configuration, send 0x3C with parity bit 1.
  - Required: `parity_err`=1; nothing transmitted; `fifo_level`=0.
  - Then pulse `clr_err`: `parity_err`=0.
- Framing error and glitch rejection:
  - Stimulus: send 0x55 with stop bit 0.
  - Required: `frame_err`=1, no write.
  - Stimulus: drive a 3-cycle low glitch on the line.
  - Required: RX returns to IDLE; no flags; `fifo_level`=0.
- Overflow (FIFO_DEPTH=4):
  - Stimulus: hold `echo_en`=0, send 0x01..0x05.
  - Required: `fifo_level`=4 and `overflow`=1.
  - Then set `echo_en`=1. Required: 0x01, 0x02, 0x03, 0x04 are transmitted in order and 0x05 never appears.
- Width and stop bits (DATA_BITS=5, PARITY=1, STOP_BITS=2):
  - Stimulus: send 0x13.
  - Required: TX frame = start, 1,1,0,0,1, parity 0, then 32 high cycles.
- Reset mid-TX:
  - Stimulus: assert `rst` during data bit 3.
  - Required: `UART_RXD_OUT`=1 immediately; `fifo_level`=0; after release the next received byte echoes correctly.
